fs4_serial: RTL and testbench



---
 rtl/fs4_serial_pkg.sv | 11 +
 rtl/fs4_serial_if.sv | 27 ++
 rtl/fs4_serial_fs1.sv | 12 +
 rtl/fs4_serial.sv | 95 +++++++++
 tb/tb_fs4_serial.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/fs4_serial_pkg.sv
// fs4_serial shared types.
// FSM state encoding and default operand width.
package fs_pkg;
  localparam int FS_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } fs_state_t;
endpackage

// File: rtl/fs4_serial_if.sv
// Operand/result handshake bundle
// for the serial subtractor.
interface fs4_serial_if
  import fs_pkg::*;
#(
  parameter int WIDTH = FS_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout
  );
endinterface

// File: rtl/fs4_serial_fs1.sv
// 1-bit full subtractor cell.
// d = a - b - bin, bout = borrow.
module fs1 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/fs4_serial.sv
// Bit-serial subtractor: one fs1 cell
// walked LSB-first across the operands.
module fs4_serial
  import fs_pkg::*;
#(
  parameter int WIDTH = FS_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  fs4_serial_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  fs_state_t        state, state_n;
  logic [WIDTH-1:0] sa, sb, res;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH:0]   res_sh;
  logic [CW-1:0]    cnt;
  logic             br, bout_q;
  logic             d, br_n;
  logic             in_ready, out_valid;
  logic             last;

  fs1 u_fs1 (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (br),
    .d    (d),
    .bout (br_n)
  );

  assign last   = (cnt == CW'(WIDTH - 1));
  assign res_sh = {d, res};

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = ~rst;
        if (bus.in_valid) state_n = SHIFT;
      end
      SHIFT: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // result is published only on the final
  // bit, so diff never shows a partial value
  always_ff @(posedge clk) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      if (state == IDLE && bus.in_valid) begin
        sa  <= bus.a;
        sb  <= bus.b;
        br  <= bus.bin;
        cnt <= '0;
      end else if (state == SHIFT) begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        res <= res_sh[WIDTH:1];
        br  <= br_n;
        cnt <= cnt + CW'(1);
        if (last) begin
          diff_q <= res_sh[WIDTH:1];
          bout_q <= br_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_fs4_serial.sv
// Directed and exhaustive checks for
// the serial 4-bit subtractor.
module tb_fs4_serial;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fs4_serial_if #(.WIDTH(4)) bus ();

  fs4_serial #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // call at a negedge; returns 1ns after accept edge
  task automatic accept_op(input logic [3:0] a,
                           input logic [3:0] b,
                           input logic bin);
    int n;
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", int'(n >= 20), 0);
    @(posedge clk);
    #1;
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
    bus.a        = ~a;
    bus.b        = ~b;
    bus.bin      = ~bin;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 30);
    chk("valid_timeout", int'(lat >= 30), 0);
  endtask

  logic [3:0] va [4] = '{4'd9, 4'd3, 4'd0, 4'd15};
  logic [3:0] vb [4] = '{4'd5, 4'd5, 4'd0, 4'd15};
  logic       vc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  int         vd [4] = '{4, 13, 15, 0};
  int         ve [4] = '{0, 1, 1, 0};

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, prev, n, e_d, e_b;
    bit seen;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_diff", bus.diff, 0);
    chk("rst_bout", bus.bout, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", bus.in_ready, 1);

    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      accept_op(va[i], vb[i], vc[i]);
      @(negedge clk);
      chk("shift_in_ready", bus.in_ready, 0);
      chk("shift_out_valid", bus.out_valid, 0);
      lat = 1;
      while (!bus.out_valid && lat < 30) begin
        @(negedge clk);
        lat++;
      end
      chk("latency", lat, 5);
      chk("vec_diff", bus.diff, vd[i]);
      chk("vec_bout", bus.bout, ve[i]);
      chk("done_in_ready", bus.in_ready, 0);
      @(negedge clk);
      chk("one_cycle_valid", bus.out_valid, 0);
      chk("post_in_ready", bus.in_ready, 1);
    end

    // backpressure with busy-time input garbage
    bus.out_ready = 1'b0;
    accept_op(4'd12, 4'd7, 1'b0);
    bus.a        = 4'd3;
    bus.b        = 4'd9;
    bus.bin      = 1'b1;
    bus.in_valid = 1'b1;
    wait_valid(lat);
    for (int i = 0; i < 6; i++) begin
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_diff", bus.diff, 5);
      chk("bp_bout", bus.bout, 0);
      chk("bp_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_valid", bus.out_valid, 0);
    chk("bp_rel_in_ready", bus.in_ready, 1);
    chk("bp_hold_diff", bus.diff, 5);

    // reset during the second SHIFT cycle
    @(negedge clk);
    accept_op(4'd8, 4'd1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_diff", bus.diff, 0);
    chk("mid_rst_bout", bus.bout, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    accept_op(4'd6, 4'd2, 1'b0);
    wait_valid(lat);
    chk("after_rst_diff", bus.diff, 4);
    chk("after_rst_bout", bus.bout, 0);
    @(negedge clk);

    // exhaustive, random output backpressure
    prev = -1;
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          e_d = (ia - ib - ic) & 15;
          e_b = int'(ia < ib + ic);
          accept_op(4'(ia), 4'(ib), 1'(ic));
          if (prev >= 0)
            chk("ex_period", int'(acc_cyc - prev >= 6), 1);
          prev = acc_cyc;
          seen = 1'b0;
          n = 0;
          do begin
            @(negedge clk);
            n++;
            bus.out_ready = 1'($urandom_range(0, 1));
            if (bus.out_valid && !seen) begin
              seen = 1'b1;
              chk("ex_diff", bus.diff, e_d);
              chk("ex_bout", bus.bout, e_b);
            end
          end while (!(bus.out_valid && bus.out_ready) && n < 100);
          chk("ex_timeout", int'(n >= 100), 0);
        end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
